curve_lut_loader: RTL and testbench
===================================

CURVE_LUT_LOADER -- requirements
Module: curve_lut_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning pixel and table-entry width.
REQ-002 SHALL have parameter LUT_DEPTH, default 256, meaning entries per table (2^DATA_WIDTH).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 lut_wr_valid  input  1  table byte offered.
REQ-007 lut_wr_data  input  DATA_WIDTH  table entry, sent in address order 0..LUT_DEPTH-1.
REQ-008 lut_wr_ready  output  1  loader accepts a byte this cycle.
REQ-009 lut_load_done  output  1  one-cycle pulse when the new table becomes active.
REQ-010 per_frame_vsync / per_frame_href / per_frame_clken  input  1 each  input video sync and pixel strobe.
REQ-011 per_img_Y  input  DATA_WIDTH  input grey pixel.
REQ-012 post_frame_vsync / post_frame_href / post_frame_clken  output  1 each  sync delayed to match data.
REQ-013 post_img_Y  output  DATA_WIDTH  mapped pixel.

Function
REQ-014 SHALL hold two table banks (active, shadow); lookups read active, loads write shadow only.
REQ-015 SHALL accept a byte when lut_wr_valid and lut_wr_ready are both high, writing it to shadow[wr_addr], then incrementing wr_addr.
REQ-016 Loader FSM SHALL have states IDLE (ready=1, wr_addr=0), LOAD (ready=1), PEND (ready=0).
REQ-017 IDLE->LOAD on first accepted byte; LOAD->PEND when byte at address LUT_DEPTH-1 is accepted; PEND->IDLE on swap.
REQ-018 Swap SHALL occur only in PEND on a per_frame_vsync rising edge (vsync high, registered vsync low); swap toggles bank select, sets lut_valid=1, pulses lut_load_done in the cycle after the edge.
REQ-019 If the last byte is accepted in the same cycle as a vsync rising edge, swap SHALL wait for the next rising edge.
REQ-020 A vsync rising edge in IDLE or LOAD SHALL NOT swap; a partial load continues across frames.
REQ-021 lut_wr_valid in PEND SHALL be ignored; no write, no address change.
REQ-022 Pixel path latency SHALL be exactly 1 clk: post_img_Y = table[per_img_Y] registered; post_frame_* = per_frame_* registered.
REQ-023 While lut_valid=0, post_img_Y SHALL equal per_img_Y delayed 1 clk (identity bypass).
REQ-024 Lookup SHALL run every cycle regardless of clken; post_img_Y is meaningful only when post_frame_clken=1.
REQ-025 Bank select SHALL only change at swap, so a frame never mixes two tables.

Reset
REQ-026 On rst: FSM=IDLE, wr_addr=0, bank select=0, lut_valid=0, vsync register=0, lut_load_done=0, post_frame_*=0, post_img_Y=0; table RAM contents not reset.
REQ-027 Reset mid-load SHALL discard the partial load; next accepted byte writes address 0.

Structure
REQ-028 Package curve_lut_pkg SHALL hold DATA_WIDTH/LUT_DEPTH defaults and the loader state encoding.
REQ-029 SHALL instantiate one sub-module curve_lut_dpram: simple dual-port RAM, 2*LUT_DEPTH x DATA_WIDTH, bank bit as address MSB, synchronous read.

Verification
REQ-030 Reset, no load; pixels 0x00,0x7F,0xFF with clken=1 -> post_img_Y 0x00,0x7F,0xFF one clk later, lut_load_done never pulses.
REQ-031 Load table 255-x (256 bytes, continuous valid), then vsync rising edge -> lut_load_done pulse one clk after edge; pixel 0x10 -> 0xEF, 0xFF -> 0x00, 1-clk latency.
REQ-032 After REQ-031, hold lut_wr_valid=1 in PEND for 10 clks before vsync -> lut_wr_ready=0, no writes; wr_addr still 0 after swap.
REQ-033 Load 100 bytes of a new table (x/2), vsync edge, finish remaining 156 -> no swap at first edge, active table still 255-x; swap at next edge, then 0x80 -> 0x40.
REQ-034 Mid-frame during pixel stream, complete a second load -> all pixels of current frame use old table; new table from frame after next vsync edge.
REQ-035 Assert rst after 50 bytes loaded -> ready=1, bypass restored (lut_valid=0); full reload of 256 bytes plus vsync gives correct mapping from address 0.

Source files
------------

// File: rtl/curve_lut_pkg.sv
// Shared defaults and loader state encoding for the curve LUT loader.
package curve_lut_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int LUT_DEPTH_DEF  = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PEND = 2'd2
   } loader_state_t;

endpackage

// File: rtl/curve_lut_dpram.sv
// Simple dual-port RAM holding both table banks; the bank bit is the address MSB.
module curve_lut_dpram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   // Write port and registered read port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/curve_lut_loader.sv
// Grey-level curve mapping with a double-buffered table that is streamed in
// byte by byte and made active only on a vsync rising edge.
module curve_lut_loader
   import curve_lut_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LUT_DEPTH  = LUT_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lut_wr_valid,
   input  logic [DATA_WIDTH-1:0] lut_wr_data,
   output logic                  lut_wr_ready,
   output logic                  lut_load_done,
   input  logic                  per_frame_vsync,
   input  logic                  per_frame_href,
   input  logic                  per_frame_clken,
   input  logic [DATA_WIDTH-1:0] per_img_Y,
   output logic                  post_frame_vsync,
   output logic                  post_frame_href,
   output logic                  post_frame_clken,
   output logic [DATA_WIDTH-1:0] post_img_Y
);

   localparam int ADDR_W = $clog2(LUT_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);

   loader_state_t         state;
   loader_state_t         state_nxt;
   logic [ADDR_W-1:0]     wr_addr;
   logic                  bank_sel;
   logic                  lut_valid;
   logic                  vsync_d;
   logic                  use_lut;
   logic [DATA_WIDTH-1:0] bypass_y;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  accept;
   logic                  vsync_rise;
   logic                  swap;

   assign lut_wr_ready = (state == ST_IDLE) || (state == ST_LOAD);
   assign accept       = lut_wr_valid && lut_wr_ready;
   assign vsync_rise   = per_frame_vsync && !vsync_d;

   // Loader next state; a swap is only possible once the full shadow table is in.
   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = (wr_addr == LAST_ADDR) ? ST_PEND : ST_LOAD;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (accept && (wr_addr == LAST_ADDR)) begin
               state_nxt = ST_PEND;
            end else begin
               state_nxt = ST_LOAD;
            end
         end
         ST_PEND: begin
            if (vsync_rise) begin
               swap      = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_PEND;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Loader state, write address, bank select and load-done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         wr_addr       <= '0;
         bank_sel      <= 1'b0;
         lut_valid     <= 1'b0;
         vsync_d       <= 1'b0;
         lut_load_done <= 1'b0;
      end else begin
         state         <= state_nxt;
         vsync_d       <= per_frame_vsync;
         lut_load_done <= swap;
         if (swap) begin
            bank_sel  <= ~bank_sel;
            lut_valid <= 1'b1;
            wr_addr   <= '0;
         end else if (accept) begin
            wr_addr <= wr_addr + ADDR_W'(1);
         end
      end
   end

   curve_lut_dpram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_W + 1)
   ) u_dpram (
      .clk   (clk),
      .we    (accept),
      .waddr ({~bank_sel, wr_addr}),
      .wdata (lut_wr_data),
      .raddr ({bank_sel, per_img_Y[ADDR_W-1:0]}),
      .rdata (ram_rdata)
   );

   // Sync and bypass pipeline aligned with the one-cycle RAM read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         post_frame_vsync <= 1'b0;
         post_frame_href  <= 1'b0;
         post_frame_clken <= 1'b0;
         bypass_y         <= '0;
         use_lut          <= 1'b0;
      end else begin
         post_frame_vsync <= per_frame_vsync;
         post_frame_href  <= per_frame_href;
         post_frame_clken <= per_frame_clken;
         bypass_y         <= per_img_Y;
         use_lut          <= lut_valid;
      end
   end

   // The select is sampled with the read address, so the swap cycle stays consistent.
   always_comb begin
      post_img_Y = bypass_y;
      if (use_lut) begin
         post_img_Y = ram_rdata;
      end else begin
         post_img_Y = bypass_y;
      end
   end

endmodule

// File: tb/tb_curve_lut_loader.sv
// Directed self-checking bench for curve_lut_loader: bypass, load/swap timing,
// PEND write blocking, split loads across frames and reset mid-load.
module tb_curve_lut_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       lut_wr_valid;
   logic [7:0] lut_wr_data;
   logic       lut_wr_ready;
   logic       lut_load_done;
   logic       per_frame_vsync;
   logic       per_frame_href;
   logic       per_frame_clken;
   logic [7:0] per_img_Y;
   logic       post_frame_vsync;
   logic       post_frame_href;
   logic       post_frame_clken;
   logic [7:0] post_img_Y;

   int n_cmp    = 0;
   int n_bad    = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   curve_lut_loader #(
      .DATA_WIDTH (8),
      .LUT_DEPTH  (256)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .lut_wr_valid     (lut_wr_valid),
      .lut_wr_data      (lut_wr_data),
      .lut_wr_ready     (lut_wr_ready),
      .lut_load_done    (lut_load_done),
      .per_frame_vsync  (per_frame_vsync),
      .per_frame_href   (per_frame_href),
      .per_frame_clken  (per_frame_clken),
      .per_img_Y        (per_img_Y),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .post_img_Y       (post_img_Y)
   );

   // The done pulse lasts one full cycle, so sampling on the falling edge counts it once.
   always @(negedge clk) begin
      if (lut_load_done === 1'b1) done_cnt++;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Table contents: 0 = inverse, 1 = half, other = xor 0x5A.
   function automatic logic [7:0] f_tab(input int kind, input int i);
      logic [7:0] v;
      v = 8'(i);
      case (kind)
         0:       return 8'hFF - v;
         1:       return v >> 1;
         default: return v ^ 8'h5A;
      endcase
   endfunction

   task automatic load(input int kind, input int first, input int count, input int old_kind);
      logic [7:0] y;
      for (int i = first; i < first + count; i++) begin
         lut_wr_valid = 1'b1;
         lut_wr_data  = f_tab(kind, i);
         if (old_kind >= 0) begin
            y               = 8'(i) ^ 8'h33;
            per_img_Y       = y;
            per_frame_clken = 1'b1;
            per_frame_href  = 1'b1;
         end
         step;
         if (old_kind >= 0) check("stream_old_table", post_img_Y, f_tab(old_kind, int'(y)));
      end
      lut_wr_valid    = 1'b0;
      per_frame_clken = 1'b0;
      per_frame_href  = 1'b0;
   endtask

   task automatic pix(input logic [7:0] y, input logic [7:0] exp, input string tag);
      per_img_Y       = y;
      per_frame_clken = 1'b1;
      per_frame_href  = 1'b1;
      step;
      check(tag, post_img_Y, exp);
      check({tag, "_clken"}, post_frame_clken, 1);
      per_frame_clken = 1'b0;
      per_frame_href  = 1'b0;
   endtask

   task automatic vsync_edge(input logic [7:0] y, input logic [7:0] exp_y, input logic exp_done,
                             input string tag);
      per_frame_vsync = 1'b1;
      per_img_Y       = y;
      per_frame_clken = 1'b1;
      step;
      check({tag, "_pix"}, post_img_Y, exp_y);
      check({tag, "_done"}, lut_load_done, exp_done);
      check({tag, "_vsync_out"}, post_frame_vsync, 1);
      per_frame_clken = 1'b0;
      step;
      check({tag, "_done_clear"}, lut_load_done, 0);
      per_frame_vsync = 1'b0;
      step;
   endtask

   initial begin
      rst             = 1'b1;
      lut_wr_valid    = 1'b0;
      lut_wr_data     = 8'h00;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      per_img_Y       = 8'h00;
      step;
      step;
      check("rst_post_y", post_img_Y, 0);
      check("rst_post_vsync", post_frame_vsync, 0);
      check("rst_post_href", post_frame_href, 0);
      check("rst_post_clken", post_frame_clken, 0);
      check("rst_done", lut_load_done, 0);
      check("rst_ready", lut_wr_ready, 1);
      rst = 1'b0;
      step;

      // Identity bypass before any table is loaded.
      pix(8'h00, 8'h00, "bypass_00");
      pix(8'h7F, 8'h7F, "bypass_7f");
      pix(8'hFF, 8'hFF, "bypass_ff");
      check("bypass_no_done", done_cnt, 0);

      // Inverse table, then writes held off while pending.
      load(0, 0, 256, -1);
      check("pend_ready", lut_wr_ready, 0);
      for (int k = 0; k < 10; k++) begin
         lut_wr_valid = 1'b1;
         lut_wr_data  = 8'hAA;
         step;
         check("pend_ready_hold", lut_wr_ready, 0);
      end
      check("pend_wr_addr", dut.wr_addr, 0);
      lut_wr_valid = 1'b0;
      vsync_edge(8'h10, 8'h10, 1'b1, "swap1");
      check("swap1_wr_addr", dut.wr_addr, 0);
      check("swap1_count", done_cnt, 1);
      pix(8'h10, 8'hEF, "inv_10");
      pix(8'hFF, 8'h00, "inv_ff");
      pix(8'h00, 8'hFF, "inv_00");

      // Partial load straddles a vsync edge without swapping.
      load(1, 0, 100, -1);
      vsync_edge(8'h80, 8'h7F, 1'b0, "partial_edge");
      pix(8'h80, 8'h7F, "partial_old");
      load(1, 100, 156, -1);
      vsync_edge(8'h80, 8'h7F, 1'b1, "swap2");
      pix(8'h80, 8'h40, "half_80");
      pix(8'hFF, 8'h7F, "half_ff");
      pix(8'h03, 8'h01, "half_03");

      // Load under a live pixel stream; last byte coincides with a vsync edge.
      load(2, 0, 255, 1);
      lut_wr_valid    = 1'b1;
      lut_wr_data     = f_tab(2, 255);
      per_frame_vsync = 1'b1;
      per_img_Y       = 8'h44;
      per_frame_clken = 1'b1;
      step;
      check("coincide_done", lut_load_done, 0);
      check("coincide_pix", post_img_Y, 8'h22);
      check("coincide_ready", lut_wr_ready, 0);
      lut_wr_valid    = 1'b0;
      per_frame_clken = 1'b0;
      step;
      check("coincide_done_late", lut_load_done, 0);
      per_frame_vsync = 1'b0;
      step;
      pix(8'h44, 8'h22, "coincide_old");
      vsync_edge(8'h44, 8'h22, 1'b1, "swap3");
      pix(8'h44, 8'h1E, "xor_44");
      pix(8'hFF, 8'hA5, "xor_ff");
      pix(8'h00, 8'h5A, "xor_00");
      check("swap3_count", done_cnt, 3);

      // Reset in the middle of a load discards it and restores bypass.
      load(1, 0, 50, -1);
      rst = 1'b1;
      #1;
      check("midrst_ready", lut_wr_ready, 1);
      check("midrst_post_y", post_img_Y, 0);
      check("midrst_done", lut_load_done, 0);
      step;
      rst = 1'b0;
      check("midrst_wr_addr", dut.wr_addr, 0);
      pix(8'h10, 8'h10, "midrst_bypass");
      load(0, 0, 256, -1);
      vsync_edge(8'h20, 8'h20, 1'b1, "swap4");
      pix(8'h00, 8'hFF, "reload_00");
      pix(8'h31, 8'hCE, "reload_31");
      pix(8'h32, 8'hCD, "reload_32");
      pix(8'hFF, 8'h00, "reload_ff");
      check("final_count", done_cnt, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
